// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the single data-RAM port: M0 is the CPU data path, M1 is the loader/DMA master.
// Latency: grants and the RAM mux are combinational; rvalid0/rvalid1 rise one cycle after a granted read.
// Backpressure: the losing master holds its request (M0 sees cpu_stall); define ARB_ROUND_ROBIN_EN for round-robin IDLE arbitration.
module ram_port_arbiter #(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [3:0]  we0,
    input  logic [9:0]  addr0,
    input  logic [31:0] wdata0,
    output logic        gnt0,
    output logic        rvalid0,
    input  logic        req1,
    input  logic [3:0]  we1,
    input  logic [9:0]  addr1,
    input  logic [31:0] wdata1,
    input  logic        lock1,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic [9:0]  ram_addr,
    output logic [3:0]  ram_wea,
    output logic [31:0] ram_dina,
    input  logic [31:0] ram_douta,
    output logic        cpu_stall,
    output logic [3:0]  wait_cnt,
    output logic [7:0]  burst_cnt
);
    localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, LOCK1, RECOVER} state_t;

    state_t state;
    logic   m1_wins;

`ifdef ARB_ROUND_ROBIN_EN
    // High when M0 was granted most recently, so M1 takes the next contended cycle.
    logic rr_ptr;
    assign m1_wins = rr_ptr;
`else
    assign m1_wins = (wait_cnt == WAIT_MAX);
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            LOCK1: begin
                gnt1 = req1;
            end
            RECOVER: begin
                gnt0 = req0;
                gnt1 = req1 & ~req0;
            end
            default: begin
                if (req0 & req1) begin
                    gnt1 = m1_wins;
                    gnt0 = ~m1_wins;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

    always_comb begin
        ram_wea  = '0;
        ram_addr = '0;
        ram_dina = '0;
        if (gnt1) begin
            ram_wea  = we1;
            ram_addr = addr1;
            ram_dina = wdata1;
        end else if (gnt0) begin
            ram_wea  = we0;
            ram_addr = addr0;
            ram_dina = wdata0;
        end
    end

    assign rdata     = ram_douta;
    assign cpu_stall = req0 & ~gnt0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            burst_cnt <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            rvalid0 <= gnt0 & (we0 == 4'b0000);
            rvalid1 <= gnt1 & (we1 == 4'b0000);

            if (req1 & ~gnt1) begin
                if (wait_cnt < WAIT_MAX)
                    wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end

`ifdef ARB_ROUND_ROBIN_EN
            if (gnt0)
                rr_ptr <= 1'b1;
            else if (gnt1)
                rr_ptr <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (gnt1 & lock1) begin
                        burst_cnt <= 8'd1;
                        state     <= (BURST_MAX == 8'd1) ? RECOVER : LOCK1;
                    end
                end
                LOCK1: begin
                    if (gnt1)
                        burst_cnt <= burst_cnt + 8'd1;
                    // A burst that hits its length limit on this grant hands the port back to M0.
                    if (~lock1 || (gnt1 && (burst_cnt + 8'd1 == BURST_MAX)))
                        state <= RECOVER;
                end
                RECOVER: begin
                    burst_cnt <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single data-RAM port (10-bit word address, 4-bit byte write enables, 32-bit data) between two requesters.
- M0 is the CPU data path, taken from the bus decoder's RAM outputs; its stall output drives the CPU's MIO_ready.
- M1 is a secondary master: program loader or debug/DMA engine.
- Sits between the bus decoder and the RAM. Arbitration is per cycle, with a starvation guard and an M1 locked-burst mode.

Parameters:
- MAX_WAIT, 4: contention cycles M1 may lose in a row before it is forced to win. Range 1..15.
- MAX_BURST, 16: maximum consecutive locked M1 grants. Range 1..255.

Ports:
- clk in 1: system clock; everything is on the rising edge.
- rst in 1: synchronous, active-high reset.
- req0 in 1: M0 access request.
- we0 in 4: M0 byte write enables; 0 means read.
- addr0 in 10: M0 word address.
- wdata0 in 32: M0 write data.
- gnt0 out 1: M0 granted this cycle (combinational).
- rvalid0 out 1: M0 read data valid (registered).
- req1 / we1 / addr1 / wdata1 in 1/4/10/32: M1 request, same meaning as M0.
- lock1 in 1: M1 requests burst ownership.
- gnt1 out 1: M1 granted this cycle (combinational).
- rvalid1 out 1: M1 read data valid (registered).
- rdata out 32: ram_douta routed unchanged to both masters.
- ram_addr out 10: to RAM address.
- ram_wea out 4: to RAM byte write enables.
- ram_dina out 32: to RAM write data.
- ram_douta in 32: from RAM read data.
- cpu_stall out 1: req0 & ~gnt0; drives MIO_ready low.
- wait_cnt out 4: current M1 starvation count.
- burst_cnt out 8: current locked-burst length.

Behaviour:
- Reset: state=IDLE, wait_cnt=0, burst_cnt=0, rvalid0=rvalid1=0, priority pointer → M0. Outputs then settle to: gnt0=req0, gnt1=req1&~req0, cpu_stall=0.
- At most one of gnt0/gnt1 is high in any cycle.
- RAM mux:
  - Granted master's we/addr/wdata drive ram_wea/ram_addr/ram_dina combinationally.
  - No grant: ram_wea=0, ram_addr=0, ram_dina=0.
- Read return:
  - rvalidN=1 exactly one cycle after a cycle with gntN & (weN==0).
  - rdata is valid while rvalidN is high.
  - Writes never raise rvalid.
- A losing master holds req/we/addr/wdata stable until granted. The arbiter has no internal request queue.
- FSM IDLE (per-cycle arbitration):
  - Only one request: grant it.
  - Both request: grant M1 if wait_cnt==MAX_WAIT, else M0.
  - wait_cnt: +1 on each cycle with req1 & ~gnt1, saturating at MAX_WAIT. Cleared on gnt1 or ~req1.
  - Under continuous contention, M1 wins exactly on its (MAX_WAIT+1)th cycle.
  - gnt1 & lock1 → LOCK1; burst_cnt becomes 1.
- FSM LOCK1:
  - M1 owns the port; gnt1=req1 regardless of req0; gnt0=0.
  - burst_cnt +1 per gnt1.
  - Exit to RECOVER when lock1 falls, or when burst_cnt==MAX_BURST after a grant.
  - req1 low while lock1 is high: port idles with no grant; stay in LOCK1.
- FSM RECOVER (one cycle):
  - gnt0=req0 unconditionally; gnt1=req1&~req0. Lock is ignored.
  - burst_cnt cleared; next state IDLE.
  - Guarantees M0 progress between bursts.
- Simultaneous exit and request: lock1 falling in the same cycle as a new req0 → req0 is served in RECOVER on the next cycle.
- Reset mid-burst: the synchronous rst wins over every transition. Next cycle is IDLE, counters 0, rvalid 0.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE contention goes to the master not granted most recently; a 1-bit pointer updates on every grant.
  - wait_cnt still counts and is reported, but does not affect arbitration.
  - LOCK1 and RECOVER are unchanged.
- Undefined: fixed M0 priority with the MAX_WAIT starvation guard, as described above.

Test Plan:
- Reset, then req0 read addr 0x010 (RAM holds 0xDEADBEEF) → gnt0 same cycle; next cycle rvalid0=1, rdata=0xDEADBEEF; cpu_stall=0.
- req0 and req1 held continuously, MAX_WAIT=4 → gnt0 on cycles 1–4, gnt1 on cycle 5, then gnt0. wait_cnt reads 1,2,3,4,0; cpu_stall=1 only on cycle 5.
- M1 lock1=1 with req1, 20 writes to addr 0x100+i, req0 high throughout, MAX_BURST=16 → 16 gnt1 cycles, then one RECOVER cycle with gnt0, then normal arbitration. RAM 0x100–0x10F is written with data i.
- M1 write we1=4'b0011, data 0x12345678, to addr 0x020 (prior value 0xAAAAAAAA) → M0 read returns 0xAAAA5678; rvalid1 never asserted.
- rst asserted in the 3rd cycle of a locked burst → next cycle gnt1=0 while req0 present, gnt0=1, burst_cnt=0, wait_cnt=0, rvalid0/1=0.
- Build with ARB_ROUND_ROBIN_EN, both requesting for 6 cycles → grants alternate M0,M1,M0,M1,M0,M1.
